// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel synchroniser, debounce filter, edge and long-press event generator
module multi_debouncer #(
  parameter int N_CH         = 4,
  parameter int STABLE_COUNT = 3,
  parameter int HOLD_COUNT   = 0,
  parameter bit RST_VAL      = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] hold_out,
  output logic [N_CH-1:0] hold_pulse
);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_COUNT - 1);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sync0, sync1, clean, rise, fall, qual, clean_nxt;
    logic [SW-1:0] cnt;
    assign qual      = (sync1 != clean) && (cnt == S_LAST);
    assign clean_nxt = qual ? sync1 : clean;
    // synchronise the raw input, qualify disagreement run length, emit edge events
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sync0 <= RST_VAL;
        sync1 <= RST_VAL;
        clean <= RST_VAL;
        cnt   <= '0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        sync0 <= noisy_in[i];
        sync1 <= sync0;
        clean <= clean_nxt;
        cnt   <= (sync1 == clean || qual) ? '0 : cnt + SW'(1);
        rise  <= qual && sync1;
        fall  <= qual && !sync1;
      end
    assign clean_out[i]  = clean;
    assign rise_pulse[i] = rise;
    assign fall_pulse[i] = fall;
    if (HOLD_COUNT > 0) begin : g_hold
      localparam int HW = $clog2(HOLD_COUNT + 1);
      localparam logic [HW-1:0] H_LAST = HW'(HOLD_COUNT - 1);
      logic [HW-1:0] hcnt;
      logic hold, hpulse, fire;
      assign fire = clean_nxt && clean && !hold && (hcnt == H_LAST);
      // time the high level and latch a long-press until the debounced level falls
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          hcnt   <= '0;
          hold   <= 1'b0;
          hpulse <= 1'b0;
        end else begin
          hcnt   <= !clean_nxt ? '0 : (clean && !hold) ? hcnt + HW'(1) : hcnt;
          hold   <= clean_nxt && (hold || fire);
          hpulse <= fire;
        end
      assign hold_out[i]   = hold;
      assign hold_pulse[i] = hpulse;
    end else begin : g_no_hold
      assign hold_out[i]   = 1'b0;
      assign hold_pulse[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: scenario tasks with a per-edge expected-output scoreboard
module tb_multi_debouncer;
  localparam int H = 10;
  logic clk, rst;
  logic [3:0] noisy_in, clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse;
  typedef struct packed {logic [3:0] c, r, f, h, p;} snap_t;
  snap_t exp_q[$];
  snap_t e;
  logic [19:0] got;
  logic [3:0] pc;
  int run[4];
  int checks = 0;
  int errors = 0;

  multi_debouncer #(.N_CH(4), .STABLE_COUNT(4), .HOLD_COUNT(H), .RST_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .hold_out(hold_out), .hold_pulse(hold_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected events derived from the expected debounced level sequence
  function automatic void push_exp(input logic [3:0] c);
    snap_t s;
    s.c = c;
    s.r = c & ~pc;
    s.f = ~c & pc;
    for (int k = 0; k < 4; k++) begin
      run[k] = c[k] ? run[k] + 1 : 0;
      s.h[k] = run[k] > H;
      s.p[k] = run[k] == H + 1;
    end
    pc = c;
    exp_q.push_back(s);
  endfunction

  function automatic void clear_model();
    pc = 4'h0;
    for (int k = 0; k < 4; k++) run[k] = 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    noisy_in = 4'hF;
    clear_model();
    #1;
    checks++;
    if ({clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL reset_async got %h exp 00000", {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse});
    end
    for (int k = 1; k <= 3; k++) begin
      push_exp(4'h0);
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_hold edge=%0d got %h exp %h", k, got, e);
      end
    end
    rst = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      noisy_in = (t <= 7) ? 4'hF : 4'h0;
      push_exp((t >= 6 && t < 13) ? 4'hF : 4'h0);
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_release edge=%0d got %h exp %h", t, got, e);
      end
    end
  endtask

  task automatic test_glitch();
    for (int t = 1; t <= 10; t++) begin
      noisy_in = {3'b000, t <= 3};
      push_exp(4'h0);
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL glitch3 edge=%0d got %h exp %h", t, got, e);
      end
    end
    for (int t = 1; t <= 14; t++) begin
      noisy_in = {3'b000, t <= 4};
      push_exp({3'b000, t >= 6 && t <= 9});
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL glitch4 edge=%0d got %h exp %h", t, got, e);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pre;
    pre = 5'b10110;
    for (int t = 1; t <= 22; t++) begin
      noisy_in = {2'b00, (t <= 5) ? pre[5-t] : (t <= 12), 1'b0};
      push_exp({2'b00, t >= 11 && t < 18, 1'b0});
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bounce edge=%0d got %h exp %h", t, got, e);
      end
    end
  endtask

  task automatic test_long_press();
    for (int t = 1; t <= 28; t++) begin
      noisy_in = {1'b0, t <= 19, 2'b00};
      push_exp({1'b0, t >= 6 && t < 25, 2'b00});
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL long_press edge=%0d got %h exp %h", t, got, e);
      end
    end
  endtask

  task automatic test_short_press();
    for (int t = 1; t <= 17; t++) begin
      noisy_in = {t <= 8, 3'b000};
      push_exp({t >= 6 && t < 14, 3'b000});
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL short_press edge=%0d got %h exp %h", t, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int t = 1; t <= 18; t++) begin
      noisy_in = 4'b0100;
      push_exp({1'b0, t >= 6, 2'b00});
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_hold_pre edge=%0d got %h exp %h", t, got, e);
      end
    end
    rst = 1'b1;
    clear_model();
    #1;
    checks++;
    if ({clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL mid_hold_async got %h exp 00000", {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse});
    end
    for (int k = 1; k <= 2; k++) begin
      push_exp(4'h0);
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_hold_rst edge=%0d got %h exp %h", k, got, e);
      end
    end
    rst = 1'b0;
    for (int t = 1; t <= 27; t++) begin
      noisy_in = {1'b0, t <= 18, 2'b00};
      push_exp({1'b0, t >= 6 && t < 24, 2'b00});
      @(posedge clk); #1;
      got = {clean_out, rise_pulse, fall_pulse, hold_out, hold_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_hold_post edge=%0d got %h exp %h", t, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_long_press();
    test_short_press();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
